// File: rtl/alu_scheduler_if.sv
// Handshake bundle between issue logic, alu_scheduler and the shared ALU.
// slave: scheduler side; master: requesters, consumer and ALU side.
interface alu_scheduler_if #(
  parameter int w = 3
);
  logic         req0_valid;
  logic         req0_ready;
  logic [w-1:0] req0_opcode;
  logic [w-1:0] req0_a;
  logic [w-1:0] req0_b;
  logic         req1_valid;
  logic         req1_ready;
  logic [w-1:0] req1_opcode;
  logic [w-1:0] req1_a;
  logic [w-1:0] req1_b;
  logic [w-1:0] alu_opcode;
  logic [w-1:0] alu_a;
  logic [w-1:0] alu_b;
  logic [w-1:0] alu_y;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [w-1:0] rsp_y;
  logic         rsp_z;
  logic         rsp_n;
  logic         rsp_err;
  logic         busy;

  modport slave (
    input  req0_valid, req0_opcode, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_opcode, req1_a, req1_b,
    output req1_ready,
    output alu_opcode, alu_a, alu_b,
    input  alu_y,
    output rsp_valid, rsp_id, rsp_y, rsp_z, rsp_n, rsp_err,
    input  rsp_ready,
    output busy
  );

  modport master (
    output req0_valid, req0_opcode, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_opcode, req1_a, req1_b,
    input  req1_ready,
    input  alu_opcode, alu_a, alu_b,
    output alu_y,
    input  rsp_valid, rsp_id, rsp_y, rsp_z, rsp_n, rsp_err,
    output rsp_ready,
    input  busy
  );
endinterface

// File: rtl/alu_scheduler.sv
// Round-robin sharing of one ALU between two requesters.
// Operands and result are registered; one op in flight at a time.
module alu_scheduler #(
  parameter int w = 3
) (
  input logic      clk,
  input logic      rst,
  alu_scheduler_if.slave io
);
  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t       state_q, state_d;
  logic         last_q, last_d;
  logic         id_q, id_d;
  logic [w-1:0] op_q, op_d;
  logic [w-1:0] a_q, a_d;
  logic [w-1:0] b_q, b_d;
  logic [w-1:0] y_q, y_d;
  logic         z_q, z_d;
  logic         n_q, n_d;
  logic         err_q, err_d;
  logic         gnt0, gnt1;
  logic         rdy0, rdy1;

  always_comb begin
    gnt0 = io.req0_valid & (~io.req1_valid | last_q);
    gnt1 = io.req1_valid & (~io.req0_valid | ~last_q);
    rdy0 = ~rst & (state_q == IDLE) & gnt0;
    rdy1 = ~rst & (state_q == IDLE) & gnt1;

    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    y_d     = y_q;
    z_d     = z_q;
    n_d     = n_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        unique case (1'b1)
          rdy0: begin
            op_d    = io.req0_opcode;
            a_d     = io.req0_a;
            b_d     = io.req0_b;
            id_d    = 1'b0;
            last_d  = 1'b0;
            state_d = EXEC;
          end
          rdy1: begin
            op_d    = io.req1_opcode;
            a_d     = io.req1_a;
            b_d     = io.req1_b;
            id_d    = 1'b1;
            last_d  = 1'b1;
            state_d = EXEC;
          end
          default: state_d = IDLE;
        endcase
      end
      EXEC: begin
        y_d     = io.alu_y;
        z_d     = (io.alu_y == '0);
        n_d     = io.alu_y[w-1];
        err_d   = (op_q > w'(2));
        state_d = RESP;
      end
      RESP: begin
        if (io.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      y_q     <= y_d;
      z_q     <= z_d;
      n_q     <= n_d;
      err_q   <= err_d;
    end
  end

  assign io.req0_ready = rdy0;
  assign io.req1_ready = rdy1;
  assign io.alu_opcode = op_q;
  assign io.alu_a      = a_q;
  assign io.alu_b      = b_q;
  assign io.rsp_valid  = (state_q == RESP);
  assign io.rsp_id     = id_q;
  assign io.rsp_y      = y_q;
  assign io.rsp_z      = z_q;
  assign io.rsp_n      = n_q;
  assign io.rsp_err    = err_q;
  assign io.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_alu_scheduler.sv
// Directed scoreboard bench for alu_scheduler with a behavioural ALU.
// ALU: 0 sll, 1 srl, 2 sra, anything else sll.
module tb_alu_scheduler;
  localparam int W = 3;

  typedef struct packed {
    logic         id;
    logic [W-1:0] y;
    logic         z;
    logic         n;
    logic         err;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail = 0;
  rsp_t sb[$];

  always #5 clk = ~clk;

  alu_scheduler_if #(.w(W)) io ();

  alu_scheduler #(.w(W)) dut (
    .clk(clk),
    .rst(rst),
    .io (io.slave)
  );

  function automatic logic [W-1:0] alu_f(
    input logic [W-1:0] op,
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    logic signed [W-1:0] sa;
    sa = $signed(a);
    case (op)
      3'd1:    return a >> b;
      3'd2:    return W'(sa >>> b);
      default: return a << b;
    endcase
  endfunction

  always_comb io.alu_y = alu_f(io.alu_opcode, io.alu_a, io.alu_b);

  function automatic rsp_t model(
    input logic         id,
    input logic [W-1:0] op,
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    rsp_t r;
    r.id  = id;
    r.y   = alu_f(op, a, b);
    r.z   = (r.y == '0);
    r.n   = r.y[W-1];
    r.err = (op > 3'd2);
    return r;
  endfunction

  task automatic chk(
    input string      tag,
    input logic [7:0] obs,
    input logic [7:0] exp
  );
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rsp_valid"}, io.rsp_valid, 0);
    chk({tag, "_rsp_y"}, io.rsp_y, 0);
    chk({tag, "_rsp_id"}, io.rsp_id, 0);
    chk({tag, "_rsp_z"}, io.rsp_z, 0);
    chk({tag, "_rsp_n"}, io.rsp_n, 0);
    chk({tag, "_rsp_err"}, io.rsp_err, 0);
    chk({tag, "_alu_op"}, io.alu_opcode, 0);
    chk({tag, "_alu_a"}, io.alu_a, 0);
    chk({tag, "_alu_b"}, io.alu_b, 0);
    chk({tag, "_busy"}, io.busy, 0);
    chk({tag, "_rdy0"}, io.req0_ready, 0);
    chk({tag, "_rdy1"}, io.req1_ready, 0);
  endtask

  // Entered just after a negedge; returns one cycle after the accept edge.
  task automatic accept(
    input string tag,
    input logic  eid,
    input int    maxc
  );
    int   k;
    logic r0, r1;
    k = 0;
    #1;
    while (!(io.req0_ready | io.req1_ready) && k < maxc) begin
      @(negedge clk);
      #1;
      k++;
    end
    r0 = io.req0_ready;
    r1 = io.req1_ready;
    chk({tag, "_rdy"}, r0 | r1, 1);
    chk({tag, "_onehot"}, r0 & r1, 0);
    chk({tag, "_gnt"}, r1, eid);
    if (r0)
      sb.push_back(model(1'b0, io.req0_opcode, io.req0_a, io.req0_b));
    else if (r1)
      sb.push_back(model(1'b1, io.req1_opcode, io.req1_a, io.req1_b));
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic get_rsp(input string tag, input int maxc);
    int   k;
    rsp_t e;
    k = 0;
    while (io.rsp_valid !== 1'b1 && k < maxc) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk({tag, "_valid"}, io.rsp_valid, 1);
    if (io.rsp_valid === 1'b1) begin
      chk({tag, "_sb_nonempty"}, sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({tag, "_id"}, io.rsp_id, e.id);
        chk({tag, "_y"}, io.rsp_y, e.y);
        chk({tag, "_z"}, io.rsp_z, e.z);
        chk({tag, "_n"}, io.rsp_n, e.n);
        chk({tag, "_err"}, io.rsp_err, e.err);
      end
      @(posedge clk);
      @(negedge clk);
      #1;
    end
  endtask

  task automatic set_req(
    input logic         id,
    input logic         v,
    input logic [W-1:0] op,
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    if (id) begin
      io.req1_valid = v; io.req1_opcode = op;
      io.req1_a = a; io.req1_b = b;
    end else begin
      io.req0_valid = v; io.req0_opcode = op;
      io.req0_a = a; io.req0_b = b;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    io.rsp_ready = 1'b1;
    set_req(0, 1, 3'd0, 3'b011, 3'd1);
    set_req(1, 0, 3'd0, 3'd0, 3'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk_zero("reset");

    // single op: 011 << 1
    rst = 1'b0;
    accept("t1", 0, 0);
    io.req0_valid = 1'b0;
    chk("t1_exec_valid", io.rsp_valid, 0);
    chk("t1_exec_busy", io.busy, 1);
    @(negedge clk);
    #1;
    chk("t1_lat_valid", io.rsp_valid, 1);
    chk("t1_y_const", io.rsp_y, 3'b110);
    chk("t1_n_const", io.rsp_n, 1);
    chk("t1_z_const", io.rsp_z, 0);
    chk("t1_id_const", io.rsp_id, 0);
    chk("t1_err_const", io.rsp_err, 0);
    get_rsp("t1", 0);
    chk("t1_done_valid", io.rsp_valid, 0);
    chk("t1_done_busy", io.busy, 0);

    // simultaneous requests straight after reset
    rst = 1'b1;
    set_req(0, 1, 3'd1, 3'b110, 3'd1);
    set_req(1, 1, 3'd2, 3'b100, 3'd1);
    @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
    accept("t2a", 0, 0);
    @(negedge clk);
    #1;
    chk("t2a_y_const", io.rsp_y, 3'b011);
    get_rsp("t2a", 0);
    accept("t2b", 1, 0);
    @(negedge clk);
    #1;
    chk("t2b_y_const", io.rsp_y, 3'b110);
    chk("t2b_id_const", io.rsp_id, 1);
    get_rsp("t2b", 0);

    // next tie goes to req0, then held under backpressure
    io.rsp_ready = 1'b0;
    accept("t3", 0, 0);
    @(negedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("t3_valid", io.rsp_valid, 1);
      chk("t3_y", io.rsp_y, 3'b011);
      chk("t3_id", io.rsp_id, 0);
      chk("t3_alu_op", io.alu_opcode, 3'd1);
      chk("t3_alu_a", io.alu_a, 3'b110);
      chk("t3_alu_b", io.alu_b, 3'd1);
      chk("t3_rdy0", io.req0_ready, 0);
      chk("t3_rdy1", io.req1_ready, 0);
      chk("t3_busy", io.busy, 1);
      @(negedge clk);
      #1;
    end
    io.rsp_ready = 1'b1;
    get_rsp("t3", 0);
    accept("t3n", 1, 0);
    get_rsp("t3n", 2);

    // zero result and illegal opcode
    io.req1_valid = 1'b0;
    set_req(0, 1, 3'd1, 3'b001, 3'd1);
    accept("t4a", 0, 0);
    @(negedge clk);
    #1;
    chk("t4a_y_const", io.rsp_y, 3'b000);
    chk("t4a_z_const", io.rsp_z, 1);
    get_rsp("t4a", 0);
    set_req(0, 1, 3'b101, 3'b001, 3'd1);
    accept("t4b", 0, 0);
    @(negedge clk);
    #1;
    chk("t4b_err_const", io.rsp_err, 1);
    chk("t4b_y_const", io.rsp_y, 3'b010);
    get_rsp("t4b", 0);

    // reset while in EXEC
    set_req(0, 1, 3'd0, 3'b001, 3'd2);
    accept("t5a", 0, 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk_zero("t5a_rst");
    sb.delete();
    rst = 1'b0;
    io.req0_valid = 1'b0;
    set_req(1, 1, 3'd0, 3'b010, 3'd1);
    accept("t5a_fresh", 1, 0);
    io.req1_valid = 1'b0;
    get_rsp("t5a_fresh", 2);

    // reset while in RESP
    set_req(0, 1, 3'd0, 3'b011, 3'd1);
    accept("t5b", 0, 0);
    @(negedge clk);
    #1;
    chk("t5b_in_resp", io.rsp_valid, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk_zero("t5b_rst");
    sb.delete();
    rst = 1'b0;
    io.req0_valid = 1'b0;
    set_req(1, 1, 3'd2, 3'b110, 3'd1);
    accept("t5b_fresh", 1, 0);
    io.req1_valid = 1'b0;
    get_rsp("t5b_fresh", 2);

    // sustained throughput: one accept every 3 cycles
    for (int i = 0; i < 6; i++) begin
      set_req(0, 1, 3'(i % 4), 3'($urandom_range(0, 7)),
              3'($urandom_range(0, 2)));
      accept("t6", 0, 0);
      chk("t6_exec_valid", io.rsp_valid, 0);
      @(negedge clk);
      #1;
      get_rsp("t6", 0);
      chk("t6_pulse_end", io.rsp_valid, 0);
    end
    io.req0_valid = 1'b0;

    chk("sb_empty", sb.size() == 0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_scheduler.md
# alu_scheduler

Shares one `alu` instance between two requesters. Round-robin arbitration picks one request, and a valid/ready handshake captures its opcode and operands. The block drives the ALU from registered operands, registers the result together with derived flags, and returns it on a single response channel tagged with the requester ID. It sits between the instruction-issue logic and the ALU/shifter datapath, and it is the only block that drives the ALU inputs.

## Interface
Parameters:
- w, 3, datapath width; opcode, operand and result width (matches `alu`).

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_opcode  in  w  requester 0 ALU opcode
- req0_a  in  w  requester 0 operand a
- req0_b  in  w  requester 0 operand b / shift amount
- req1_valid, req1_ready, req1_opcode, req1_a, req1_b: same as above, for requester 1
- alu_opcode  out  w  to ALU opcode, registered
- alu_a  out  w  to ALU a, registered
- alu_b  out  w  to ALU b, registered
- alu_y  in  w  from ALU y, combinational result
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  1  requester that issued the result (0/1)
- rsp_y  out  w  registered ALU result
- rsp_z  out  1  rsp_y == 0
- rsp_n  out  1  rsp_y[w-1]
- rsp_err  out  1  opcode was not 0, 1 or 2
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If neither valid is asserted, stay in IDLE.
  - If exactly one valid is asserted, grant it.
  - If both are asserted, grant the requester that was not granted last. The last_grant register resets to 1, so requester 0 wins the first tie.
  - The granted reqN_ready is asserted combinationally in the same cycle. The handshake completes when valid and ready are both high at the edge.
  - At the handshake edge: latch opcode/a/b into alu_opcode/alu_a/alu_b, set id := N, set last_grant := N, go to EXEC.
- EXEC: the ALU evaluates the registered inputs. At the edge, capture rsp_y := alu_y, rsp_z, rsp_n, and rsp_err := (alu_opcode > 2). Go to RESP.
- RESP: rsp_valid = 1. When rsp_ready is high at the edge, go to IDLE. Otherwise hold; all rsp_* and alu_* stay stable.
- Both reqN_ready are 0 in EXEC and RESP, and whenever rst = 1. A new request is never accepted in the same cycle as a response handshake.
- Illegal opcodes (3..2^w−1) are still issued. The ALU default behaviour is a logical left shift, so rsp_y carries that result and rsp_err = 1.
- Requester inputs are sampled only at the handshake edge. Later changes while valid is low or the block is busy have no effect.
- Reset, including reset mid-operation in EXEC or RESP:
  - State goes to IDLE.
  - All outputs go to 0: rsp_valid, rsp_y, rsp_id, rsp_z, rsp_n, rsp_err, alu_opcode, alu_a, alu_b, busy, req0_ready, req1_ready.
  - last_grant goes to 1.
  - The in-flight operation is dropped with no response.

## Timing
- Handshake at edge E0 → EXEC in cycle E0..E1 → rsp_valid is high from E1. Latency is 2 cycles from acceptance to response valid.
- With rsp_ready held high, the response handshake is at E2 and the next request can be accepted at E3. Peak throughput is 1 operation per 3 cycles.
- Backpressure on rsp_ready extends RESP indefinitely. No other timeouts exist.
- busy is high from E0 until the edge of the response handshake.
- The combinational path reqN_valid → reqN_ready exists only in IDLE. The scheduler contains no combinational paths through the ALU: alu_y is only registered.

## Test plan
- Reset then single op, w=3:
  - Stimulus: req0 with opcode 0, a=3'b011, b=1.
  - Required: req0_ready high in the accept cycle; rsp_valid exactly 2 cycles later; rsp_y=3'b110, rsp_n=1, rsp_z=0, rsp_id=0, rsp_err=0.
- Simultaneous requests:
  - Stimulus: both valid from the first cycle after reset; req0 opcode 1, a=3'b110, b=1; req1 opcode 2, a=3'b100, b=1.
  - Required: first response id=0, y=3'b011; second response id=1, y=3'b110. The next tie is granted to req0.
- Backpressure:
  - Stimulus: hold rsp_ready low for 5 cycles with both requesters valid.
  - Required: rsp_y, rsp_id and alu_* stay stable; both readies stay 0; busy=1. Releasing rsp_ready completes the response and the next grant follows one cycle later.
- Zero and illegal opcode:
  - Stimulus: opcode 1, a=3'b001, b=1.
  - Required: rsp_y=0, rsp_z=1.
  - Stimulus: opcode 3'b101, a=3'b001, b=1.
  - Required: rsp_err=1, rsp_y=3'b010.
- Reset mid-operation:
  - Stimulus: assert rst in EXEC; in a separate run, assert rst in RESP.
  - Required: the next cycle shows all outputs 0 and state IDLE; no response is produced; a fresh req1-only request is accepted immediately after rst drops.
- Sustained throughput:
  - Stimulus: rsp_ready held high, req0 continuously valid.
  - Required: one accept every 3 cycles; rsp_valid is a 1-cycle pulse each time.
